// File: rtl/mem_stage_if.sv
// EX/MEM-to-MEM/WB bundle for the MEM stage: EX/MEM buffer fields in,
// PC redirect, stall and MEM/WB register fields out.
interface mem_stage_if;
   logic [31:0] i_alu_result;
   logic [31:0] i_read_rb_2;
   logic [31:0] i_branch_address;
   logic [31:0] i_jump_address;
   logic [4:0]  i_inst_mux_br_write_address;
   logic        i_zf;
   logic        i_branch;
   logic        i_jump;
   logic        i_memWrite;
   logic [1:0]  i_memRead;
   logic        i_regWrite;
   logic        i_memToReg;
   logic [5:0]  i_opcode;
   logic        i_flush;
   logic        o_stall;
   logic        o_pc_src;
   logic [31:0] o_pc_target;
   logic        o_pc_sel;
   logic        o_misalign;
   logic [31:0] o_read_data;
   logic [31:0] o_alu_result;
   logic [4:0]  o_write_address;
   logic        o_regWrite;
   logic        o_memToReg;

   modport slave (
      input  i_alu_result, i_read_rb_2, i_branch_address, i_jump_address,
             i_inst_mux_br_write_address, i_zf, i_branch, i_jump, i_memWrite,
             i_memRead, i_regWrite, i_memToReg, i_opcode, i_flush,
      output o_stall, o_pc_src, o_pc_target, o_pc_sel, o_misalign,
             o_read_data, o_alu_result, o_write_address, o_regWrite, o_memToReg
   );

   modport master (
      output i_alu_result, i_read_rb_2, i_branch_address, i_jump_address,
             i_inst_mux_br_write_address, i_zf, i_branch, i_jump, i_memWrite,
             i_memRead, i_regWrite, i_memToReg, i_opcode, i_flush,
      input  o_stall, o_pc_src, o_pc_target, o_pc_sel, o_misalign,
             o_read_data, o_alu_result, o_write_address, o_regWrite, o_memToReg
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: word/byte loads and stores against an internal RAM with
// configurable latency, PC redirect select, and the MEM/WB pipeline register.
module mem_stage #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   mem_stage_if.slave  bus
);
   localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [5:0]  OP_SB = 6'h28;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] idx_c;
   logic [1:0]        lane_c;
   logic              is_word_c;
   logic              misalign_c;
   logic              acc_c;
   logic              stall_c;
   logic              load_c;
   logic              we_c;
   logic [31:0]       rd_word_c;
   logic [7:0]        byte_c;
   logic [31:0]       load_val_c;
   logic [31:0]       wr_word_c;

   logic [31:0] read_data_q;
   logic [31:0] alu_result_q;
   logic [4:0]  write_address_q;
   logic        reg_write_q;
   logic        mem_to_reg_q;
   logic        misalign_q;

   assign idx_c      = bus.i_alu_result[ADDR_W+1:2];
   assign lane_c     = bus.i_alu_result[1:0];
   assign is_word_c  = (bus.i_memRead == 2'b01) | (bus.i_memWrite & (bus.i_opcode != OP_SB));
   assign misalign_c = is_word_c & (lane_c != 2'b00);
   assign acc_c      = (bus.i_memRead != 2'b00) | bus.i_memWrite;
   assign load_c     = ~stall_c & ~bus.i_flush;
   // Stores only reach this edge once the access has served its latency.
   assign we_c       = load_c & bus.i_memWrite & ~misalign_c;

   assign rd_word_c  = mem[idx_c];
   assign byte_c     = rd_word_c[{lane_c, 3'b000} +: 8];

   always_comb begin
      load_val_c = 32'h0;
      case (bus.i_memRead)
         2'b01:   load_val_c = rd_word_c;
         2'b10:   load_val_c = {{24{byte_c[7]}}, byte_c};
         2'b11:   load_val_c = {24'h0, byte_c};
         default: load_val_c = 32'h0;
      endcase
   end

   // sb merges one little-endian lane into the current word.
   always_comb begin
      wr_word_c = bus.i_read_rb_2;
      if (bus.i_opcode == OP_SB) begin
         wr_word_c = rd_word_c;
         wr_word_c[{lane_c, 3'b000} +: 8] = bus.i_read_rb_2[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (we_c) mem[idx_c] <= wr_word_c;
   end

   generate
      if (MEM_LATENCY > 0) begin : g_fsm
         typedef enum logic {IDLE, BUSY} state_t;
         state_t           state_q, state_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
            end
         end

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            stall_c = 1'b0;
            case (state_q)
               IDLE: begin
                  if (acc_c & ~misalign_c & ~bus.i_flush) begin
                     stall_c = 1'b1;
                     state_d = BUSY;
                     cnt_d   = CNT_W'(MEM_LATENCY - 1);
                  end
               end
               BUSY: begin
                  stall_c = (cnt_q != '0);
                  if (bus.i_flush || cnt_q == '0) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
               default: begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end else begin : g_no_fsm
         assign stall_c = 1'b0;
      end
   endgenerate

   // MEM/WB register: stall and flush both insert a bubble, other fields hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data_q     <= 32'h0;
         alu_result_q    <= 32'h0;
         write_address_q <= 5'h0;
         reg_write_q     <= 1'b0;
         mem_to_reg_q    <= 1'b0;
         misalign_q      <= 1'b0;
      end else begin
         misalign_q <= misalign_c & ~bus.i_flush;
         if (!load_c) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
         end else begin
            read_data_q     <= misalign_c ? 32'h0 : load_val_c;
            alu_result_q    <= bus.i_alu_result;
            write_address_q <= bus.i_inst_mux_br_write_address;
            reg_write_q     <= bus.i_regWrite & ~misalign_c;
            mem_to_reg_q    <= bus.i_memToReg;
         end
      end
   end

   assign bus.o_stall         = stall_c;
   assign bus.o_pc_src        = bus.i_branch & bus.i_zf;
   assign bus.o_pc_target     = bus.i_jump ? bus.i_jump_address : bus.i_branch_address;
   assign bus.o_pc_sel        = (bus.i_branch & bus.i_zf) | bus.i_jump;
   assign bus.o_misalign      = misalign_q;
   assign bus.o_read_data     = read_data_q;
   assign bus.o_alu_result    = alu_result_q;
   assign bus.o_write_address = write_address_q;
   assign bus.o_regWrite      = reg_write_q;
   assign bus.o_memToReg      = mem_to_reg_q;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM buffer.
- Consumes the EX/MEM buffer outputs and performs data-memory loads and stores (word/byte) against an internal RAM with configurable access latency.
- Resolves branch/jump PC selection and registers results into the MEM/WB pipeline register feeding write-back.
- Stalls upstream while a multi-cycle access is in flight.

Parameters:
DEPTH, 256, data-memory size in 32-bit words (power of two)
ADDR_W, 8, log2(DEPTH)
MEM_LATENCY, 2, cycles per memory access (0 = single-cycle, no stall)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_alu_result  input  32  effective address / ALU result
i_read_rb_2  input  32  store data
i_branch_address  input  32  branch target
i_jump_address  input  32  jump target
i_inst_mux_br_write_address  input  5  destination register
i_zf  input  1  ALU zero flag
i_branch  input  1  branch instruction
i_jump  input  1  jump instruction
i_memWrite  input  1  store
i_memRead  input  2  00 none, 01 lw, 10 lb (sign-extend), 11 lbu (zero-extend)
i_regWrite  input  1  write-back enable
i_memToReg  input  1  write-back source select
i_opcode  input  6  6'h28 = sb; any other opcode with memWrite = sw
i_flush  input  1  synchronous flush/abort
o_stall  output  1  hold upstream (EX/MEM) stable
o_pc_src  output  1  take branch = i_branch & i_zf (combinational)
o_pc_target  output  32  i_jump ? i_jump_address : i_branch_address (combinational)
o_pc_sel  output  1  o_pc_src | i_jump (combinational)
o_misalign  output  1  registered one-cycle pulse on a misaligned word access
o_read_data  output  32  MEM/WB: load data
o_alu_result  output  32  MEM/WB: ALU result
o_write_address  output  5  MEM/WB: destination register
o_regWrite  output  1  MEM/WB: write enable
o_memToReg  output  1  MEM/WB: source select

Behaviour:
- Reset (rst_n=0, async): FSM to IDLE, counter 0, all registered outputs 0. RAM contents are not cleared.
- Access present (acc) = (i_memRead != 0) | i_memWrite. Word index = i_alu_result[ADDR_W+1:2]; upper address bits are ignored (address wraps modulo DEPTH).
- Misaligned access: lw or sw with i_alu_result[1:0] != 0. The access is suppressed (no write, read_data = 0, no stall). o_misalign pulses 1 cycle. The MEM/WB entry loads with regWrite=0.
- Byte lanes are little-endian: byte k = word[8k+7:8k]. sb writes lane [1:0] only, other lanes unchanged. lb/lbu select lane [1:0].
- FSM, MEM_LATENCY > 0:
  - IDLE: when acc & ~misalign & ~i_flush, go to BUSY with cnt = MEM_LATENCY-1. o_stall=1 combinationally in that same cycle.
  - BUSY: o_stall=1 while cnt != 0. cnt decrements each cycle. When cnt == 0, o_stall=0; the store commits and the load data is captured at that edge; return to IDLE.
  - Net effect: an access occupies MEM_LATENCY+1 cycles. o_stall is high for the first MEM_LATENCY of them.
- FSM, MEM_LATENCY = 0: every access completes in its cycle; o_stall is tied 0.
- MEM/WB register:
  - On each edge with o_stall=0 and i_flush=0, it loads the current instruction.
  - On edges with o_stall=1, it loads a bubble: regWrite=0, memToReg=0; other fields hold.
- i_flush=1: at the next edge, MEM/WB loads a bubble and the FSM returns to IDLE. Any pending store is discarded and o_stall drops the following cycle. Flush wins over completion in the same cycle.
- Branch/jump outputs are combinational from the inputs and valid every cycle; upstream ignores them while o_stall=1.
- Simultaneous store and load on the same instruction is illegal; if it occurs, the write commits and read_data returns the pre-write value.

Test Plan:
- MEM_LATENCY=2: sw 0xDEADBEEF @0x10, then lw @0x10 → o_stall high 2 cycles per access; o_read_data=0xDEADBEEF, o_regWrite=1 after the lw completes.
- sb 0x80 @0x13 over word 0x11223344, then lb @0x13 and lbu @0x13 → word=0x80223344; lb gives 0xFFFFFF80, lbu gives 0x00000080.
- lw @0x0000_0402 → o_misalign pulse, no stall, o_regWrite=0; lw @0x0000_0410 with DEPTH=256 reads word index 4 (wrap).
- i_branch=1, i_zf=1, i_branch_address=0x40 → o_pc_src=1, o_pc_sel=1, o_pc_target=0x40; i_jump=1, i_jump_address=0x100 → o_pc_target=0x100.
- sw issued, i_flush asserted in the first BUSY cycle → memory unchanged, MEM/WB bubble, o_stall=0 next cycle.
- rst_n deasserted mid-BUSY → all outputs 0 immediately, FSM IDLE; earlier-committed RAM data preserved.
